// File: rtl/pipe_register_chain.sv
// pipe_register_chain: DEPTH-stage elastic register chain with valid/ready, flush and occupancy count.
// Latency: DEPTH cycles from an input transfer to out_valid through an empty chain.
// Backpressure: bubbles collapse; in_ready drops only when every stage (and the skid entry) is full.
//
// Build option PIPE_REG_CHAIN_SKID_EN: adds a one-entry skid register so that
// in_ready is a register output (capacity DEPTH+1). Left undefined, capacity is
// DEPTH and in_ready is combinational from out_ready through the chain.
// Legal DEPTH range is 1..16.
module pipe_register_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  localparam int CNT_W = $clog2(DEPTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] occupancy
);

`ifdef PIPE_REG_CHAIN_SKID_EN
  localparam int CAPACITY = DEPTH + 1;
`else
  localparam int CAPACITY = DEPTH;
`endif

  // Per-stage state: valid bit plus payload register.
  logic [DEPTH-1:0] valid_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // Chain control: move[i] = stage i hands its entry on this cycle,
  // can_acc[i] = stage i can take a new entry, fill[i] = stage i loads.
  logic [DEPTH-1:0] move;
  logic [DEPTH-1:0] can_acc;
  logic [DEPTH-1:0] fill;
  logic [WIDTH-1:0] nxt_dat [DEPTH];

  // Entry offered to stage 0 (either fresh input or the skid entry).
  logic             src_vld;
  logic [WIDTH-1:0] src_dat;
  logic             load0;

  logic             in_fire;
  logic             out_fire;
  logic             skid_occ;
  logic [CNT_W-1:0] cnt_q;

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];
  assign occupancy = cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Walk the chain from the output end so each stage sees whether its successor frees up.
  always_comb begin
    logic nxt_acc;
    move    = '0;
    can_acc = '0;
    nxt_acc = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      move[i]    = valid_q[i] & nxt_acc;
      can_acc[i] = ~valid_q[i] | move[i];
      nxt_acc    = can_acc[i];
    end
  end

`ifdef PIPE_REG_CHAIN_SKID_EN
  logic             skid_vld_q;
  logic [WIDTH-1:0] skid_dat_q;

  // in_ready comes straight from the skid flag, so out_ready never reaches it combinationally.
  assign in_ready = ~skid_vld_q & ~flush;
  // A held skid entry always goes first so FIFO order is kept.
  assign src_vld  = skid_vld_q | in_fire;
  assign src_dat  = skid_vld_q ? skid_dat_q : in_data;
  assign skid_occ = skid_vld_q;

  // Skid valid: set when an input arrives that stage 0 cannot take, clear once it drains.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      skid_vld_q <= 1'b0;
    end else if (skid_vld_q) begin
      if (can_acc[0]) begin
        skid_vld_q <= 1'b0;
      end
    end else if (in_fire && !can_acc[0]) begin
      skid_vld_q <= 1'b1;
    end
  end

  // Skid payload: captured only when the input is parked, otherwise held.
  always_ff @(posedge clk) begin
    if (rst) begin
      skid_dat_q <= '0;
    end else if (!skid_vld_q && in_fire && !can_acc[0]) begin
      skid_dat_q <= in_data;
    end
  end
`else
  // Without a skid, accepting input depends on stage 0 freeing up this cycle.
  assign in_ready = can_acc[0] & ~flush;
  assign src_vld  = in_fire;
  assign src_dat  = in_data;
  assign skid_occ = 1'b0;
`endif

  // Stage 0 loads only when it has room and a flush is not discarding the chain.
  assign load0 = src_vld & can_acc[0] & ~flush;

  // Work out which stages load and from where; no loads happen during a flush.
  always_comb begin
    fill       = '0;
    nxt_dat    = '{default: '0};
    fill[0]    = load0;
    nxt_dat[0] = src_dat;
    for (int i = 1; i < DEPTH; i++) begin
      fill[i]    = move[i-1] & ~flush;
      nxt_dat[i] = data_q[i-1];
    end
  end

  // Valid bits: set on load, cleared when the entry moves on, wiped by rst or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      valid_q <= '0;
    end else begin
      valid_q <= fill | (valid_q & ~move);
    end
  end

  // Stage payloads: cleared only by rst; a flush leaves stale data behind invalid stages.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (fill[i]) begin
          data_q[i] <= nxt_dat[i];
        end
      end
    end
  end

  // Occupancy: +1 per input transfer, -1 per output transfer, both in one cycle cancel.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      cnt_q <= '0;
    end else begin
      case ({in_fire, out_fire})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // The counter must always agree with the number of held entries.
  a_cnt_matches: assert property (@(posedge clk) disable iff (rst)
    int'(cnt_q) == $countones({skid_occ, valid_q}));

  // The counter can never pass the chain capacity.
  a_cnt_bounded: assert property (@(posedge clk) disable iff (rst)
    int'(cnt_q) <= CAPACITY);

  // No input may be taken in a flush cycle.
  a_flush_blocks_input: assert property (@(posedge clk) disable iff (rst)
    flush |-> !in_ready);

endmodule

// File: tb/tb_pipe_register_chain.sv
// Bench for pipe_register_chain: DEPTH=3 main instance with a scoreboard monitor,
// plus a DEPTH=1 instance for the single-register corner.
module tb_pipe_register_chain;
  localparam int WIDTH  = 32;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = $clog2(DEPTH + 2);
  localparam int CNT_W1 = $clog2(1 + 2);
`ifdef PIPE_REG_CHAIN_SKID_EN
  localparam int CAP  = DEPTH + 1;
  localparam bit SKID = 1'b1;
`else
  localparam int CAP  = DEPTH;
  localparam bit SKID = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  logic              d1_in_valid;
  logic              d1_in_ready;
  logic [WIDTH-1:0]  d1_in_data;
  logic              d1_out_valid;
  logic              d1_out_ready;
  logic [WIDTH-1:0]  d1_out_data;
  logic [CNT_W1-1:0] d1_occupancy;

  int n_checks;
  int n_fail;
  bit armed;
  logic [WIDTH-1:0] sb [$];

  pipe_register_chain #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  pipe_register_chain #(.WIDTH(WIDTH), .DEPTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .flush(1'b0),
    .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(d1_in_data),
    .out_valid(d1_out_valid), .out_ready(d1_out_ready), .out_data(d1_out_data),
    .occupancy(d1_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard monitor: inputs are driven 1ns after posedge, so negedge sees the settled handshake.
  always @(negedge clk) begin
    logic [WIDTH-1:0] exp_dat;
    if (armed) begin
      n_checks++;
      if (int'(occupancy) !== sb.size()) begin
        n_fail++;
        $display("FAIL occupancy_model: got %0d expected %0d", occupancy, sb.size());
      end
      if (rst) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          n_checks++;
          if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got %0h expected no output", out_data);
          end else begin
            exp_dat = sb.pop_front();
            if (out_data !== exp_dat) begin
              n_fail++;
              $display("FAIL sb_data: got %0h expected %0h", out_data, exp_dat);
            end
          end
        end
        if (flush) begin
          sb.delete();
        end else if (in_valid && in_ready) begin
          sb.push_back(in_data);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++;
    if (out_data !== '0) begin n_fail++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    n_checks++;
    if (occupancy !== '0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++;
    if (d1_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_d1_out_valid: got %b expected 0", d1_out_valid); end
    sb.delete();
    armed = 1'b1;
  endtask

  task automatic test_latency();
    @(posedge clk); #1;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h11;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL latency_in_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (out_valid !== (k == DEPTH)) begin
        n_fail++;
        $display("FAIL latency_out_valid_T+%0d: got %b expected %b", k, out_valid, (k == DEPTH));
      end
    end
    n_checks++;
    if (out_data !== 32'h11) begin n_fail++; $display("FAIL latency_out_data: got %0h expected 11", out_data); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int got;
    int first_c;
    bit gap;
    logic [WIDTH-1:0] seen [$];
    got = 0; first_c = -1; gap = 1'b0;
    for (int c = 0; c < 8 + DEPTH + 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = (c < 8); in_data = WIDTH'(c + 1);
      @(negedge clk);
      if (c < 8) begin
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready_c%0d: got %b expected 1", c, in_ready); end
      end
      if (out_valid) begin
        if (got == 0) first_c = c;
        else if (c != first_c + got) gap = 1'b1;
        got++;
        seen.push_back(out_data);
      end
    end
    #1 in_valid = 1'b0;
    n_checks++;
    if (got !== 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", got); end
    n_checks++;
    if (gap !== 1'b0) begin n_fail++; $display("FAIL stream_gap: got %b expected 0", gap); end
    n_checks++;
    if (first_c !== DEPTH) begin n_fail++; $display("FAIL stream_first_cycle: got %0d expected %0d", first_c, DEPTH); end
    for (int k = 0; k < seen.size(); k++) begin
      n_checks++;
      if (seen[k] !== WIDTH'(k + 1)) begin n_fail++; $display("FAIL stream_order_%0d: got %0h expected %0h", k, seen[k], k + 1); end
    end
  endtask

  task automatic test_backpressure();
    int acc;
    int n_out;
    acc = 0;
    for (int c = 0; c < CAP + 3; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = WIDTH'(32'h20 + acc);
      @(negedge clk);
      if (in_ready) acc++;
    end
    n_checks++;
    if (acc !== CAP) begin n_fail++; $display("FAIL bp_accepts: got %0d expected %0d", acc, CAP); end
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if (int'(occupancy) !== CAP) begin n_fail++; $display("FAIL bp_occupancy: got %0d expected %0d", occupancy, CAP); end
    n_checks++;
    if (out_data !== 32'h20) begin n_fail++; $display("FAIL bp_head: got %0h expected 20", out_data); end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    n_out = 0;
    for (int c = 0; c < CAP + DEPTH + 2; c++) begin
      @(negedge clk);
      if (out_valid) n_out++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (n_out !== CAP) begin n_fail++; $display("FAIL bp_drained: got %0d expected %0d", n_out, CAP); end
    @(negedge clk);
    n_checks++;
    if (occupancy !== '0) begin n_fail++; $display("FAIL bp_empty: got %0d expected 0", occupancy); end
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = WIDTH'(32'hA + k);
      @(negedge clk);
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL flush_fill_%0d: got %b expected 1", k, in_ready); end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== CNT_W'(3)) begin n_fail++; $display("FAIL flush_full: got %0d expected 3", occupancy); end
    @(posedge clk); #1;
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 32'hDD;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL flush_in_ready: got %b expected 0", in_ready); end
    n_checks++;
    if (out_valid !== 1'b1 || out_data !== 32'hA) begin
      n_fail++; $display("FAIL flush_head: got %b/%0h expected 1/a", out_valid, out_data);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== '0) begin n_fail++; $display("FAIL flush_occupancy: got %0d expected 0", occupancy); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", out_valid); end
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic test_depth1();
    @(posedge clk); #1;
    d1_in_valid = 1'b1; d1_in_data = 32'h77; d1_out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_empty_ready: got %b expected 1", d1_in_ready); end
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1_out_valid !== 1'b1 || d1_out_data !== 32'h77) begin
      n_fail++; $display("FAIL d1_hold: got %b/%0h expected 1/77", d1_out_valid, d1_out_data);
    end
    n_checks++;
    if (d1_in_ready !== SKID) begin n_fail++; $display("FAIL d1_full_ready: got %b expected %b", d1_in_ready, SKID); end
    @(posedge clk); #1;
    d1_in_valid = 1'b1; d1_in_data = 32'h78; d1_out_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (d1_in_ready !== 1'b1) begin n_fail++; $display("FAIL d1_pass_ready: got %b expected 1", d1_in_ready); end
    @(posedge clk); #1;
    d1_in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1_out_valid !== 1'b1 || d1_out_data !== 32'h78 || d1_occupancy !== CNT_W1'(1)) begin
      n_fail++; $display("FAIL d1_swap: got %b/%0h/%0d expected 1/78/1", d1_out_valid, d1_out_data, d1_occupancy);
    end
    @(posedge clk); #1;
    d1_out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (d1_out_valid !== 1'b0 || d1_occupancy !== '0) begin
      n_fail++; $display("FAIL d1_drained: got %b/%0d expected 0/0", d1_out_valid, d1_occupancy);
    end
  endtask

  task automatic test_reset_mid();
    int n_out;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = WIDTH'(32'h51 + k);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== CNT_W'(2)) begin n_fail++; $display("FAIL rstmid_pre: got %0d expected 2", occupancy); end
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== '0) begin n_fail++; $display("FAIL rstmid_occupancy: got %0d expected 0", occupancy); end
    n_checks++;
    if (out_valid !== 1'b0 || out_data !== '0) begin
      n_fail++; $display("FAIL rstmid_out: got %b/%0h expected 0/0", out_valid, out_data);
    end
    n_out = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (out_valid) n_out++;
    end
    n_checks++;
    if (n_out !== 0) begin n_fail++; $display("FAIL rstmid_leak: got %0d expected 0", n_out); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; armed = 1'b0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    d1_in_valid = 1'b0; d1_in_data = '0; d1_out_ready = 1'b0;
    test_reset();
    test_latency();
    test_stream();
    test_backpressure();
    test_flush();
    test_depth1();
    test_reset_mid();
    n_checks++;
    if (sb.size() !== 0) begin n_fail++; $display("FAIL sb_leftover: got %0d expected 0", sb.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
